// File: rtl/multi_8_pkg.sv
// Shared constants for the 8x8 unsigned array multiplier.
//   OP_W   : operand width (a, b)
//   PROD_W : product width (o)
package multi_8_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
endpackage : multi_8_pkg

// File: rtl/multi_8_if.sv
// Operand/product bundle for multi_8.
//   a : multiplicand, unsigned, OP_W bits
//   b : multiplier, unsigned, OP_W bits
//   o : registered product, PROD_W bits
// master drives the operands and observes the product; slave is the multiplier.
interface multi_8_if;
    import multi_8_pkg::*;

    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] o;

    modport master (output a, output b, input o);
    modport slave  (input a, input b, output o);
endinterface : multi_8_if

// File: rtl/multi_8_full_adder.sv
// One-bit full adder cell used to build the multiplier array.
//   x, y, cin : addend bits and carry in
//   s, cout   : sum and carry out
// Half-adder positions reuse this cell with cin tied low.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule : full_adder

// File: rtl/multi_8.sv
// 8x8 unsigned array multiplier with a registered 16-bit product.
//   clk     : clock, product loaded on every rising edge
//   rst_n   : asynchronous active-low reset, clears the product
//   bus.a   : multiplicand (slave modport input)
//   bus.b   : multiplier   (slave modport input)
//   bus.o   : registered product a*b, one cycle latency
// The array is carry-save: seven rows of adder cells, each row folding one
// partial-product row into the running sum/carry vectors, followed by a
// ripple carry-propagate stage that resolves the upper product bits.
module multi_8
    import multi_8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    multi_8_if.slave   bus
);

    logic [OP_W-1:0][OP_W-1:0] pp;     // pp[i][j] = a[j] & b[i], weight i+j
    logic [PROD_W-1:0]         prod;
    logic [PROD_W-1:0]         o_d;
    logic [PROD_W-1:0]         o_q;

    genvar gi, gj;

    for (gi = 0; gi < OP_W; gi++) begin : g_pp
        assign pp[gi] = bus.a & {OP_W{bus.b[gi]}};
    end

    assign prod[0] = pp[0][0];

    // Cell (i,j) has weight i+j. Its x input is the previous row's sum one
    // position up; the top cell instead takes the previous row's MSB
    // partial product, which no earlier cell has consumed.
    for (gi = 1; gi < OP_W; gi++) begin : g_row
        logic [OP_W-2:0] s;
        logic [OP_W-2:0] c;
        for (gj = 0; gj < OP_W-1; gj++) begin : g_cell
            logic x_in;
            logic cin_in;
            if (gi == 1) begin : g_first
                assign x_in   = pp[0][gj+1];
                assign cin_in = 1'b0;
            end else begin : g_inner
                if (gj < OP_W-2) begin : g_sum
                    assign x_in = g_row[gi-1].s[gj+1];
                end else begin : g_msb
                    assign x_in = pp[gi-1][OP_W-1];
                end
                assign cin_in = g_row[gi-1].c[gj];
            end
            full_adder u_fa (
                .x    (x_in),
                .y    (pp[gi][gj]),
                .cin  (cin_in),
                .s    (s[gj]),
                .cout (c[gj])
            );
        end
        assign prod[gi] = s[0];
    end

    // Carry-propagate stage: merges the last row's sums and carries into
    // product bits OP_W..PROD_W-1.
    for (gj = 0; gj < OP_W-1; gj++) begin : g_cpa
        logic x_in;
        logic cin_in;
        logic co;
        if (gj < OP_W-2) begin : g_sum
            assign x_in = g_row[OP_W-1].s[gj+1];
        end else begin : g_msb
            assign x_in = pp[OP_W-1][OP_W-1];
        end
        if (gj == 0) begin : g_lsb
            assign cin_in = 1'b0;
        end else begin : g_chain
            assign cin_in = g_cpa[gj-1].co;
        end
        full_adder u_fa (
            .x    (x_in),
            .y    (g_row[OP_W-1].c[gj]),
            .cin  (cin_in),
            .s    (prod[OP_W+gj]),
            .cout (co)
        );
    end

    assign prod[PROD_W-1] = g_cpa[OP_W-2].co;

    assign o_d = prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign bus.o = o_q;

endmodule : multi_8

// File: tb/tb_multi_8.sv
// Self-checking bench for multi_8: directed corner cases, latency and reset
// behaviour, then random operands checked against plain a*b arithmetic.
module tb_multi_8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [15:0] wide_b;

    multi_8_if bus ();

    multi_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_prod(input int x, input int y);
        return (x % 256) * (y % 256);
    endfunction

    // Drive operands away from the edge, clock once, check the new product.
    task automatic apply(input string tag, input int x, input int y);
        @(negedge clk);
        bus.a = 8'(x);
        bus.b = 8'(y);
        @(posedge clk);
        #1;
        check_val(tag, int'(bus.o), ref_prod(x, y));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.a = 8'd200;
        bus.b = 8'd200;
        #3;
        check_val("reset_no_edge", int'(bus.o), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_held", int'(bus.o), 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("release_before_edge", int'(bus.o), 0);
        @(posedge clk);
        #1;
        check_val("release_first_edge", int'(bus.o), 40000);

        apply("1x1", 1, 1);
        apply("3x3", 3, 3);
        apply("17x17", 17, 17);
        apply("20x50", 20, 50);
        apply("100x100", 100, 100);

        // Wide value truncated by the 8-bit port: 6500 -> 100.
        @(negedge clk);
        wide_b = 16'd6500;
        bus.a = 8'd10;
        bus.b = wide_b[7:0];
        @(posedge clk);
        #1;
        check_val("10x6500_trunc", int'(bus.o), 1000);

        apply("255x255", 255, 255);
        apply("0x255", 0, 255);
        apply("255x0", 255, 0);
        apply("128x2", 128, 2);
        apply("1xb", 1, 173);

        // Mid-cycle operand change must not reach o before the next edge.
        apply("latency_base", 20, 50);
        #2;
        bus.a = 8'd7;
        bus.b = 8'd9;
        #1;
        check_val("latency_hold", int'(bus.o), 1000);
        @(posedge clk);
        #1;
        check_val("latency_update", int'(bus.o), 63);

        // Back-to-back random operands, one per edge.
        for (int k = 0; k < 300; k++) begin
            apply("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges.
        apply("pre_reset", 100, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_clear", int'(bus.o), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_hold_edges", int'(bus.o), 0);
        @(negedge clk);
        bus.a = 8'd12;
        bus.b = 8'd34;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_reset_load", int'(bus.o), 408);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multi_8
